// File: rtl/tlul_sram_adapter.sv
// tlul_sram_adapter: TL-UL device port driving a single-port, 1-cycle-latency SRAM.
// Responses are returned in order through a small circular queue.
package tlul_pkg;
    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;
    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;
    localparam logic [2:0] op_put_full = 3'd0;
    localparam logic [2:0] op_put_partial = 3'd1;
    localparam logic [2:0] op_get = 3'd4;
    localparam logic [2:0] op_ack = 3'd0;
    localparam logic [2:0] op_ack_data = 3'd1;
endpackage

module tlul_sram_adapter
    import tlul_pkg::*;
#(
    parameter int SramAw = 12,
    parameter int Outstanding = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  tl_h2d_t           tl_i,
    output tl_d2h_t           tl_o,
    output logic              sram_req_o,
    output logic              sram_we_o,
    output logic [SramAw-1:0] sram_addr_o,
    output logic [31:0]       sram_wdata_o,
    output logic [31:0]       sram_wmask_o,
    input  logic [31:0]       sram_rdata_i
);
    localparam int PW = Outstanding > 1 ? $clog2(Outstanding) : 1;
    localparam int CW = $clog2(Outstanding + 1);

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  size;
        logic [7:0]  source;
        logic        error;
        logic        is_read;
        logic        data_ok;
        logic [31:0] data;
    } entry_t;

    entry_t        q [Outstanding];
    entry_t        head, push;
    logic [PW-1:0] wptr, rptr, cap_ptr;
    logic [CW-1:0] count;
    logic          cap_pend, a_ready, accept, pop, is_get, is_put, misalign, err, bypass, d_valid;
    logic [3:0]    lanes;
    logic          unused;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(Outstanding - 1) ? '0 : p + 1'b1;
    endfunction

    assign unused = ^tl_i.a_param;

    assign is_get = tl_i.a_opcode == op_get;
    assign is_put = tl_i.a_opcode == op_put_full || tl_i.a_opcode == op_put_partial;
    assign misalign = (tl_i.a_size == 2'd1 && tl_i.a_address[0]) ||
                      (tl_i.a_size == 2'd2 && |tl_i.a_address[1:0]);
    // byte lanes a PutFullData of this size/offset must fully cover
    assign lanes = tl_i.a_size == 2'd0 ? 4'b0001 << tl_i.a_address[1:0] :
                   tl_i.a_size == 2'd1 ? (tl_i.a_address[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign err = !(is_get || is_put) || tl_i.a_size > 2'd2 || misalign ||
                 |(tl_i.a_address >> (SramAw + 2)) ||
                 (tl_i.a_opcode == op_put_full && (tl_i.a_mask & lanes) != lanes);

    assign a_ready = count < CW'(Outstanding) && !reset;
    assign accept = tl_i.a_valid && a_ready;

    assign sram_req_o = accept && !err;
    assign sram_we_o = is_put;
    assign sram_addr_o = tl_i.a_address[SramAw+1:2];
    assign sram_wdata_o = tl_i.a_data;
    assign sram_wmask_o = {{8{tl_i.a_mask[3]}}, {8{tl_i.a_mask[2]}},
                           {8{tl_i.a_mask[1]}}, {8{tl_i.a_mask[0]}}};

    assign push = '{opcode: is_get ? op_ack_data : op_ack, size: tl_i.a_size,
                    source: tl_i.a_source, error: err, is_read: is_get && !err,
                    data_ok: !(is_get && !err), data: '0};

    // read data arriving this cycle for the head entry is forwarded before capture
    assign head = q[rptr];
    assign bypass = cap_pend && cap_ptr == rptr;
    assign d_valid = count != '0 && (head.data_ok || bypass);
    assign pop = d_valid && tl_i.d_ready;

    always_comb begin
        tl_o = '0;
        tl_o.a_ready = a_ready;
        tl_o.d_valid = d_valid;
        tl_o.d_opcode = head.opcode;
        tl_o.d_size = head.size;
        tl_o.d_source = head.source;
        tl_o.d_error = head.error;
        tl_o.d_data = !head.is_read ? 32'h0 : bypass ? sram_rdata_i : head.data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cap_ptr <= '0;
            cap_pend <= 1'b0;
            count <= '0;
            for (int i = 0; i < Outstanding; i++) q[i] <= '0;
        end else begin
            cap_pend <= sram_req_o && !sram_we_o;
            cap_ptr <= wptr;
            if (cap_pend) begin
                q[cap_ptr].data <= sram_rdata_i;
                q[cap_ptr].data_ok <= 1'b1;
            end
            if (accept) begin
                q[wptr] <= push;
                wptr <= nxt(wptr);
            end
            if (pop) rptr <= nxt(rptr);
            count <= count + CW'(accept) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_tlul_sram_adapter.sv
// tb_tlul_sram_adapter: directed vector table plus backpressure, streaming and reset sequences.
module tb_tlul_sram_adapter;
    import tlul_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    tl_h2d_t h2d;
    tl_d2h_t d2h;
    logic sram_req, sram_we;
    logic [11:0] sram_addr;
    logic [31:0] sram_wdata, sram_wmask, sram_rdata;
    logic [31:0] mem [4096];
    int tests = 0;
    int fails = 0;

    tlul_sram_adapter #(.SramAw(12), .Outstanding(2)) dut (
        .clock(clock), .reset(reset), .tl_i(h2d), .tl_o(d2h),
        .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
        .sram_wdata_o(sram_wdata), .sram_wmask_o(sram_wmask), .sram_rdata_i(sram_rdata)
    );

    always #5 clock = ~clock;

    // SRAM macro: read data valid only in the cycle after the read request
    always @(posedge clock) begin
        sram_rdata <= 32'hBAD0_BAD0;
        if (sram_req && sram_we) mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_wdata & sram_wmask);
        if (sram_req && !sram_we) sram_rdata <= mem[sram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [1:0] sz, input logic [7:0] src,
                         input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        h2d.a_valid = v;
        h2d.a_opcode = op;
        h2d.a_size = sz;
        h2d.a_source = src;
        h2d.a_address = addr;
        h2d.a_mask = mask;
        h2d.a_data = data;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  size;
        logic [7:0]  src;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wmask;
        logic        e_err;
        logic [2:0]  e_dop;
        logic [31:0] e_data;
    } vec_t;

    vec_t vec [15];

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        h2d = '0;
        h2d.d_ready = 1'b1;
        vec[0]  = '{3'd0, 2'd2, 8'd3,  32'h100,  4'hF, 32'hDEADBEEF, 1, 1, 32'h40,  32'hFFFFFFFF, 0, 3'd0, 32'h0};
        vec[1]  = '{3'd4, 2'd2, 8'd4,  32'h100,  4'hF, 32'h0,        1, 0, 32'h40,  32'h0,        0, 3'd1, 32'hDEADBEEF};
        vec[2]  = '{3'd1, 2'd2, 8'd5,  32'h100,  4'h2, 32'h0000AB00, 1, 1, 32'h40,  32'h0000FF00, 0, 3'd0, 32'h0};
        vec[3]  = '{3'd4, 2'd2, 8'd6,  32'h100,  4'hF, 32'h0,        1, 0, 32'h40,  32'h0,        0, 3'd1, 32'hDEADABEF};
        vec[4]  = '{3'd4, 2'd2, 8'd7,  32'h102,  4'hF, 32'h0,        0, 0, 32'h0,   32'h0,        1, 3'd1, 32'h0};
        vec[5]  = '{3'd2, 2'd2, 8'd8,  32'h100,  4'hF, 32'h1,        0, 0, 32'h0,   32'h0,        1, 3'd7, 32'h0};
        vec[6]  = '{3'd4, 2'd2, 8'd9,  32'h4000, 4'hF, 32'h0,        0, 0, 32'h0,   32'h0,        1, 3'd1, 32'h0};
        vec[7]  = '{3'd0, 2'd2, 8'd10, 32'h200,  4'h7, 32'h11111111, 0, 0, 32'h0,   32'h0,        1, 3'd0, 32'h0};
        vec[8]  = '{3'd4, 2'd3, 8'd11, 32'h200,  4'hF, 32'h0,        0, 0, 32'h0,   32'h0,        1, 3'd7, 32'h0};
        vec[9]  = '{3'd0, 2'd1, 8'd12, 32'h202,  4'hC, 32'h12340000, 1, 1, 32'h80,  32'hFFFF0000, 0, 3'd0, 32'h0};
        vec[10] = '{3'd4, 2'd2, 8'd13, 32'h200,  4'hF, 32'h0,        1, 0, 32'h80,  32'h0,        0, 3'd1, 32'h12340000};
        vec[11] = '{3'd0, 2'd0, 8'd14, 32'h203,  4'h8, 32'h56000000, 1, 1, 32'h80,  32'hFF000000, 0, 3'd0, 32'h0};
        vec[12] = '{3'd4, 2'd0, 8'd15, 32'h203,  4'h8, 32'h0,        1, 0, 32'h80,  32'h0,        0, 3'd1, 32'h56340000};
        vec[13] = '{3'd4, 2'd1, 8'd16, 32'h201,  4'h3, 32'h0,        0, 0, 32'h0,   32'h0,        1, 3'd1, 32'h0};
        vec[14] = '{3'd4, 2'd2, 8'd17, 32'h3FFC, 4'hF, 32'h0,        1, 0, 32'hFFF, 32'h0,        0, 3'd1, 32'h0};

        drive(1, 3'd4, 2'd2, 8'd1, 32'h0, 4'hF, 32'h0);
        #2;
        chk("rst_a_ready", 32'(d2h.a_ready), 0);
        chk("rst_d_valid", 32'(d2h.d_valid), 0);
        chk("rst_sram_req", 32'(sram_req), 0);
        next_cycle();
        next_cycle();
        drive(0, 3'd4, 2'd2, 8'd1, 32'h0, 4'hF, 32'h0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_a_ready", 32'(d2h.a_ready), 1);

        for (int i = 0; i < 15; i++) begin
            next_cycle();
            drive(1, vec[i].op, vec[i].size, vec[i].src, vec[i].addr, vec[i].mask, vec[i].data);
            @(negedge clock);
            chk($sformatf("v%0d_a_ready", i), 32'(d2h.a_ready), 1);
            chk($sformatf("v%0d_req", i), 32'(sram_req), 32'(vec[i].e_req));
            chk($sformatf("v%0d_no_comb_d", i), 32'(d2h.d_valid), 0);
            if (vec[i].e_req) begin
                chk($sformatf("v%0d_we", i), 32'(sram_we), 32'(vec[i].e_we));
                chk($sformatf("v%0d_addr", i), 32'(sram_addr), vec[i].e_addr);
                if (vec[i].e_we) chk($sformatf("v%0d_wmask", i), sram_wmask, vec[i].e_wmask);
            end
            next_cycle();
            h2d.a_valid = 1'b0;
            @(negedge clock);
            chk($sformatf("v%0d_d_valid", i), 32'(d2h.d_valid), 1);
            chk($sformatf("v%0d_d_error", i), 32'(d2h.d_error), 32'(vec[i].e_err));
            chk($sformatf("v%0d_d_source", i), 32'(d2h.d_source), 32'(vec[i].src));
            chk($sformatf("v%0d_d_size", i), 32'(d2h.d_size), 32'(vec[i].size));
            chk($sformatf("v%0d_d_data", i), d2h.d_data, vec[i].e_data);
            if (vec[i].e_dop != 3'd7) chk($sformatf("v%0d_d_opcode", i), 32'(d2h.d_opcode), 32'(vec[i].e_dop));
        end
        next_cycle();
        @(negedge clock);
        chk("vec_drain_d_valid", 32'(d2h.d_valid), 0);

        // backpressure: three Gets with d_ready low and room for two
        next_cycle();
        h2d.d_ready = 1'b0;
        drive(1, 3'd4, 2'd2, 8'd30, 32'h100, 4'hF, 32'h0);
        @(negedge clock);
        chk("bp_acc0", 32'(d2h.a_ready), 1);
        next_cycle();
        h2d.a_source = 8'd31;
        @(negedge clock);
        chk("bp_acc1", 32'(d2h.a_ready), 1);
        chk("bp_d0_src", 32'(d2h.d_source), 30);
        chk("bp_d0_data", d2h.d_data, 32'hDEADABEF);
        next_cycle();
        h2d.a_source = 8'd32;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            chk($sformatf("bp_full%0d", c), 32'(d2h.a_ready), 0);
            chk($sformatf("bp_hold_valid%0d", c), 32'(d2h.d_valid), 1);
            chk($sformatf("bp_hold_src%0d", c), 32'(d2h.d_source), 30);
            chk($sformatf("bp_hold_data%0d", c), d2h.d_data, 32'hDEADABEF);
            next_cycle();
        end
        h2d.d_ready = 1'b1;
        @(negedge clock);
        chk("bp_full_on_pop", 32'(d2h.a_ready), 0);
        chk("bp_pop_src", 32'(d2h.d_source), 30);
        next_cycle();
        @(negedge clock);
        chk("bp_acc2", 32'(d2h.a_ready), 1);
        chk("bp_d1_src", 32'(d2h.d_source), 31);
        chk("bp_d1_data", d2h.d_data, 32'hDEADABEF);
        next_cycle();
        h2d.a_valid = 1'b0;
        @(negedge clock);
        chk("bp_d2_valid", 32'(d2h.d_valid), 1);
        chk("bp_d2_src", 32'(d2h.d_source), 32);
        next_cycle();
        @(negedge clock);
        chk("bp_empty", 32'(d2h.d_valid), 0);

        // streaming: 16 back-to-back Gets with d_ready high
        for (int i = 0; i < 17; i++) begin
            next_cycle();
            drive(i < 16, 3'd4, 2'd2, 8'(40 + i), 32'(4 * i), 4'hF, 32'h0);
            @(negedge clock);
            if (i < 16) chk($sformatf("st_a_ready%0d", i), 32'(d2h.a_ready), 1);
            if (i > 0) begin
                chk($sformatf("st_d_valid%0d", i - 1), 32'(d2h.d_valid), 1);
                chk($sformatf("st_d_src%0d", i - 1), 32'(d2h.d_source), 32'(40 + i - 1));
            end
        end

        // async reset with two outstanding responses
        next_cycle();
        h2d.d_ready = 1'b0;
        drive(1, 3'd4, 2'd2, 8'd60, 32'h100, 4'hF, 32'h0);
        next_cycle();
        h2d.a_source = 8'd61;
        next_cycle();
        h2d.a_valid = 1'b0;
        chk("ar_full", 32'(d2h.a_ready), 0);
        chk("ar_pre_valid", 32'(d2h.d_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_d_valid_drop", 32'(d2h.d_valid), 0);
        chk("ar_a_ready_low", 32'(d2h.a_ready), 0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        h2d.d_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk($sformatf("ar_no_stale%0d", c), 32'(d2h.d_valid), 0);
            chk($sformatf("ar_a_ready%0d", c), 32'(d2h.a_ready), 1);
            next_cycle();
        end
        drive(1, 3'd4, 2'd2, 8'd62, 32'h100, 4'hF, 32'h0);
        next_cycle();
        h2d.a_valid = 1'b0;
        @(negedge clock);
        chk("ar_new_valid", 32'(d2h.d_valid), 1);
        chk("ar_new_src", 32'(d2h.d_source), 62);
        chk("ar_new_data", d2h.d_data, 32'hDEADABEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tlul_sram_adapter.md
# tlul_sram_adapter

TL-UL device-side adapter that terminates one TL-UL host port (instruction or data bus of the core top level) and drives a single-port, fixed-latency SRAM macro. It accepts A-channel Get/PutFullData/PutPartialData, issues word accesses to the SRAM, buffers responses in a small in-order queue, and returns AccessAck/AccessAckData on the D channel. Illegal requests receive an error response without touching the SRAM.

## Interface

Parameters:
- `SramAw`, 12: SRAM word-address width (16 KiB default).
- `Outstanding`, 2: maximum accepted-but-unacknowledged requests; response queue depth; must be ≥1.

Ports:
- `clock`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `tl_i`  in  tlul_pkg::tl_h2d_t  A channel plus `d_ready` from host.
- `tl_o`  out  tlul_pkg::tl_d2h_t  D channel plus `a_ready` to host.
- `sram_req_o`  out  1  SRAM access this cycle; always granted.
- `sram_we_o`  out  1  1 = write.
- `sram_addr_o`  out  SramAw  word address = `a_address[SramAw+1:2]`.
- `sram_wdata_o`  out  32  `a_data`.
- `sram_wmask_o`  out  32  bit mask; byte i of `a_mask` replicated to bits 8i+7:8i.
- `sram_rdata_i`  in  32  read data, valid exactly 1 cycle after a read `sram_req_o`.

## Operation

- `a_ready` = (count < Outstanding) and not in reset. Accept = `a_valid & a_ready`.
- Error conditions on accepted request: opcode not Get(4)/PutFull(0)/PutPartial(1); `a_size` > 2; `a_address` not aligned to `a_size`; `a_address[31:SramAw+2]` ≠ 0; PutFullData with `a_mask` not covering the full `a_size` lanes.
- `sram_req_o` = accept & no error; `sram_we_o` = opcode is Put.
- On accept, push queue entry {opcode (Get→AccessAckData=1, Put→AccessAck=0), `a_size`, `a_source`, error, is_read, data_ok}. data_ok = 1 for writes and error entries; 0 for good reads.
- Cycle after a good read, `sram_rdata_i` is written into that entry and data_ok set. Entry identified by a registered write pointer of the accept cycle.
- D channel presents queue head: `d_valid` = head present & data_ok; `d_opcode`, `d_size`, `d_source` from entry; `d_data` = captured rdata for good reads, 0 otherwise; `d_error` = entry error; `d_param`, `d_sink` = 0.
- Pop on `d_valid & d_ready`. count: +1 on accept, −1 on pop, unchanged when both.
- Queue: circular, read/write pointers wrap modulo Outstanding; in-order only.
- No state machine beyond the queue/count; error requests follow the same path with no SRAM access.

## Timing

- Reset (async assert): count=0, pointers=0, all entries invalid; `d_valid`=0, `a_ready`=0 while asserted, `sram_req_o`=0. After deassertion: `a_ready`=1.
- Latency: accept in cycle N → `d_valid` at N+1 (read, write and error alike) if queue head. Never combinational A→D.
- Throughput: with `d_ready` held 1 and Outstanding ≥2, one request per cycle sustained.
- Full: count==Outstanding → `a_ready`=0, even if a pop occurs that cycle (no same-cycle bypass); `a_ready` returns 1 the cycle after the pop.
- `d_ready` low: `d_valid` and all D fields held stable until handshake.
- Reset mid-transaction: outstanding entries are discarded; no D response emitted for them.

## Test plan

- Write 0xDEADBEEF PutFull size 2 mask 0xF to 0x100, source 3 → `sram_req_o`/`sram_we_o`=1, addr 0x40, wmask 0xFFFFFFFF same cycle; next cycle D AccessAck(0), source 3, error 0. Get 0x100 → D AccessAckData data 0xDEADBEEF one cycle after accept.
- PutPartial mask 0x2 data 0x0000AB00 to 0x100 then Get → wmask 0x0000FF00; readback 0xDEADABEF.
- Errors: Get size 2 at 0x102; opcode 2 (arith); address 0x4000 with SramAw=12 → no `sram_req_o`; D error 1, data 0, latency 1.
- Backpressure: `d_ready`=0, issue 3 back-to-back Gets with Outstanding=2 → first two accepted, `a_ready`=0 thereafter; D holds first response stable; after `d_ready`=1, responses in order, third accepted cycle after first pop.
- Streaming: 16 consecutive Gets with `d_ready`=1 → 16 responses, one per cycle, sources matching request order.
- Async reset asserted with 2 outstanding → `d_valid` drops immediately; after release, count 0, `a_ready`=1, no stale response.
